// File: rtl/lsu_mem_port.sv
// MEM-stage load/store responder: runs one EX/MEM memory request as a req/ack bus transaction.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them on the bus.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        lsu_stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic        misalign_trap,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d, err_q, err_d, trap_q, trap_d;

  // Request decode: funct3[1:0] 00=B, 01=H, anything else is a word access.
  logic        is_b, is_h, trap_now;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [16:0] cnt_inc;

  assign is_b = (req_funct3[1:0] == 2'b00);
  assign is_h = (req_funct3[1:0] == 2'b01);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    if (is_b) begin
      st_be    = 4'b0001 << req_addr[1:0];
      st_wdata = {4{req_wdata[7:0]}};
    end else if (is_h) begin
      st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{req_wdata[15:0]}};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_now = (is_h & req_addr[0]) | (~is_b & ~is_h & (req_addr[1:0] != 2'b00));
`else
  assign trap_now = 1'b0;
`endif

  // Load lane selection and extension use the address/funct3 latched at accept time.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = bus_rdata[{addr_lo_q, 3'b000} +: 8];
    ld_half = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_data = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    trap_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          funct3_d  = req_funct3;
          if (trap_now) begin
            state_d  = S_RESP;
            rdata_d  = 32'd0;
            rvalid_d = 1'b1;
            trap_d   = 1'b1;
          end else begin
            state_d     = S_BUS;
            cnt_d       = 16'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_wdata_d = st_wdata;
            bus_be_d    = req_we ? st_be : 4'b1111;
          end
        end
      end
      S_BUS: begin
        if (bus_req_q && bus_ack) begin
          state_d   = S_RESP;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          rdata_d   = bus_we_q ? 32'd0 : ld_data;
          rvalid_d  = 1'b1;
        end else if (!bus_req_q) begin
          // Request was withdrawn on the limit edge; acks seen now are stale.
          state_d  = S_RESP;
          rdata_d  = 32'd0;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc[15:0];
          if (cnt_inc >= TO_LIMIT) begin
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'd0;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      trap_q      <= trap_d;
    end
  end

  assign lsu_stall     = rst_n & (((state_q == S_IDLE) & req_valid) | (state_q == S_BUS));
  assign rdata_out     = rdata_q;
  assign rdata_valid   = rvalid_q;
  assign bus_err       = err_q;
  assign misalign_trap = trap_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_be        = bus_be_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed transactions; expected responses are queued at issue
// and a negedge monitor pops and compares them on every rdata_valid pulse.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        lsu_stall;
  logic [31:0] rdata_out;
  logic        rdata_valid, bus_err, misalign_trap;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu_mem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .lsu_stall(lsu_stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .bus_err(bus_err), .misalign_trap(misalign_trap),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        trap;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    resp_t e;
    if (rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rdata_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", rdata_out, e.data);
        check("resp_bus_err", {31'd0, bus_err}, {31'd0, e.err});
        check("resp_misalign_trap", {31'd0, misalign_trap}, {31'd0, e.trap});
      end
    end
  end

  // One transaction: request held until the response cycle, bus responder acks after ack_dly
  // wait cycles (negative = never; then a stray ack is driven once bus_req drops).
  task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_dly, input logic [31:0] rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input int exp_bus_cycles,
                         input int exp_lat, input logic [31:0] exp_data,
                         input logic exp_err, input logic exp_trap);
    int cyc, stall_cnt, bus_k, lat;
    exp_q.push_back(resp_t'{exp_data, exp_err, exp_trap});
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    bus_ack    = 1'b0;
    cyc = 0; stall_cnt = 0; bus_k = 0; lat = -1;
    while (cyc < 64) begin
      #1;
      if (lsu_stall === 1'b1) stall_cnt++;
      if (rdata_valid === 1'b1) begin
        lat = cyc;
        break;
      end
      bus_ack = 1'b0;
      if (bus_req === 1'b1) begin
        check({name, "_bus_addr"}, bus_addr, exp_addr);
        check({name, "_bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
        check({name, "_bus_we"}, {31'd0, bus_we}, {31'd0, we});
        if (we) check({name, "_bus_wdata"}, bus_wdata, exp_wdata);
        if (bus_k == ack_dly) begin
          bus_ack   = 1'b1;
          bus_rdata = rd;
        end
        bus_k++;
      end else if (bus_k > 0) begin
        bus_ack = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    bus_ack   = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_stall_cycles"}, stall_cnt, exp_lat);
    check({name, "_bus_cycles"}, bus_k, exp_bus_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_funct3 = 3'b010; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_rdata_out", rdata_out, 32'd0);
    check("rst_flags", {29'd0, rdata_valid, bus_err, misalign_trap}, 32'd0);
    check("rst_stall", {31'd0, lsu_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //      name    we  f3      addr          wdata         dly rd            exp_addr      be       wdata         bc lat data          err   trap
    run_txn("lw",   0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEADBEEF, 32'h0000_0100, 4'hF,    32'h0,        1, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("rdata_hold", rdata_out, 32'hDEADBEEF);
    check("rdata_valid_pulse", {31'd0, rdata_valid}, 32'd0);
    run_txn("sb",   1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 3, 32'h0,       32'h0000_0200, 4'b1000, 32'hA5A5A5A5, 4, 5, 32'h0,        1'b0, 1'b0);
    run_txn("lb",   0, 3'b000, 32'h0000_0301, 32'h0,        0, 32'h00008000, 32'h0000_0300, 4'hF,    32'h0,        1, 2, 32'hFFFFFF80, 1'b0, 1'b0);
    run_txn("lbu",  0, 3'b100, 32'h0000_0301, 32'h0,        0, 32'h0000F000, 32'h0000_0300, 4'hF,    32'h0,        1, 2, 32'h000000F0, 1'b0, 1'b0);
    run_txn("lh",   0, 3'b001, 32'h0000_0302, 32'h0,        0, 32'h80000000, 32'h0000_0300, 4'hF,    32'h0,        1, 2, 32'hFFFF8000, 1'b0, 1'b0);
    run_txn("lhu",  0, 3'b101, 32'h0000_0302, 32'h0,        1, 32'h80000000, 32'h0000_0300, 4'hF,    32'h0,        2, 3, 32'h00008000, 1'b0, 1'b0);
    run_txn("lb2",  0, 3'b000, 32'h0000_0302, 32'h0,        0, 32'h12345678, 32'h0000_0300, 4'hF,    32'h0,        1, 2, 32'h00000034, 1'b0, 1'b0);
    run_txn("sh",   1, 3'b001, 32'h0000_0106, 32'h1234BEEF, 0, 32'h0,        32'h0000_0104, 4'b1100, 32'hBEEFBEEF, 1, 2, 32'h0,        1'b0, 1'b0);
    run_txn("sw",   1, 3'b010, 32'h0000_010C, 32'hCAFEF00D, 2, 32'h0,        32'h0000_010C, 4'hF,    32'hCAFEF00D, 3, 4, 32'h0,        1'b0, 1'b0);
    run_txn("sb1",  1, 3'b000, 32'h0000_0001, 32'h0000_0077, 0, 32'h0,       32'h0000_0000, 4'b0010, 32'h77777777, 1, 2, 32'h0,        1'b0, 1'b0);
    run_txn("lw11", 0, 3'b011, 32'h0000_0200, 32'h0,        0, 32'h0BADF00D, 32'h0000_0200, 4'hF,    32'h0,        1, 2, 32'h0BADF00D, 1'b0, 1'b0);
    run_txn("tmo",  0, 3'b010, 32'h0000_0400, 32'h0,       -1, 32'h55555555, 32'h0000_0400, 4'hF,    32'h0,        4, 6, 32'h0,        1'b1, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_txn("lw_mis",  0, 3'b010, 32'h0000_0102, 32'h0,     0, 32'h89ABCDEF, 32'h0,        4'hF,    32'h0,        0, 1, 32'h0,        1'b0, 1'b1);
    run_txn("lhu_mis", 0, 3'b101, 32'h0000_0303, 32'h0,     0, 32'hFEDC0000, 32'h0,        4'hF,    32'h0,        0, 1, 32'h0,        1'b0, 1'b1);
`else
    run_txn("lw_mis",  0, 3'b010, 32'h0000_0102, 32'h0,     0, 32'h89ABCDEF, 32'h0000_0100, 4'hF,    32'h0,        1, 2, 32'h89ABCDEF, 1'b0, 1'b0);
    run_txn("lhu_mis", 0, 3'b101, 32'h0000_0303, 32'h0,     0, 32'hFEDC0000, 32'h0000_0300, 4'hF,    32'h0,        1, 2, 32'h0000FEDC, 1'b0, 1'b0);
`endif

    // Reset while a load waits on the bus with an ack pending.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0500;
    @(negedge clk);
    #1;
    check("mid_rst_bus_req_before", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h11111111;
    @(posedge clk);
    #1;
    check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("mid_rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    check("mid_rst_stall", {31'd0, lsu_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus_ack = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_idle", {30'd0, rdata_valid, bus_req}, 32'd0);
    run_txn("lw_after_rst", 0, 3'b010, 32'h0000_0504, 32'h0, 0, 32'h22222222, 32'h0000_0504, 4'hF, 32'h0, 1, 2, 32'h22222222, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store responder for the MEM stage of the 5-stage RV32I pipeline. It takes the memory request held in the EX/MEM pipeline register (address, store data, load/store type) and runs it as a req/ack transaction on the data bus. It stalls the pipeline while the transaction is in flight and returns aligned, sign- or zero-extended load data toward MEM/WB.

## Interface
- TIMEOUT_CYCLES, 255: BUS-state cycles without bus_ack before abort; range 1..65535.
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  EX/MEM holds a load or store (is_load | mem_wen)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address (EX/MEM alu_result)
- req_wdata  in  32  store data (EX/MEM rs2_data)
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; x11 treated as W
- lsu_stall  out  1  freeze IF..EX/MEM while high
- rdata_out  out  32  extended load data; valid with rdata_valid
- rdata_valid  out  1  one-cycle completion pulse (loads and stores)
- bus_err  out  1  timeout pulse, coincident with rdata_valid
- misalign_trap  out  1  misalignment pulse, coincident with rdata_valid
- bus_req, bus_we  out  1  bus request / write strobe
- bus_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ack  in  1  bus completion
- bus_rdata  in  32  read word, sampled when bus_ack=1

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE with req_valid=1: latch addr, wdata, funct3, and we. Compute be and replicated wdata, then go to BUS (or RESP on a misalign trap).
- BUS: bus_req=1. bus_we, bus_addr, bus_wdata, and bus_be are held stable until ack. Clear the timeout counter on entry and increment it each cycle.
  - bus_ack=1: sample bus_rdata, go to RESP.
  - Counter reaches TIMEOUT_CYCLES without ack: drop bus_req, load data 0, set bus_err, go to RESP.
- RESP: rdata_valid=1 for exactly one cycle, then IDLE. A new req_valid seen in IDLE on the next cycle starts a new transaction.
- lsu_stall = rst_n & ((IDLE & req_valid) | BUS). It is low in RESP, so the pipeline advances on the edge that leaves RESP.
- Stores, byte enables and write data:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- Loads: bus_be=4'b1111. Select the lane by addr[1:0] (B) or addr[1] (H).
  - B/H are sign-extended, BU/HU zero-extended.
  - rdata_out = 0 for stores.
- Misaligned: H with addr[0]=1; W with addr[1:0]≠0.

## Timing
- Reset values: state=IDLE, all bus_* outputs 0, rdata_out=0, rdata_valid=0, bus_err=0, misalign_trap=0, counter=0.
- Reset mid-transaction: the next edge with rst_n=0 returns to IDLE and clears bus_req. The partial transaction is discarded and no rdata_valid is produced.
- bus_* outputs are registered. bus_req rises on the edge after IDLE accepts a request.
- Minimum latency, request seen to rdata_valid: 2 cycles (ack in the first BUS cycle). Each cycle of ack delay adds 1 cycle.
- Ack qualification: an ack in the same cycle bus_req is high completes the transaction. An ack while bus_req=0 is ignored.
- Timeout:
  - RESP is reached TIMEOUT_CYCLES+1 cycles after BUS entry.
  - An ack arriving in the same cycle the counter hits the limit wins: no bus_err.
- rdata_out holds its value after the rdata_valid pulse until the next completion.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned request goes IDLE→RESP with no bus cycle. A store writes nothing.
  - RESP gives rdata_out=0 with misalign_trap=1 alongside rdata_valid.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalign_trap tied 0.
  - Misaligned requests run normally on the bus. Offending low address bits are ignored: H uses addr[1] only; W uses lane 0.

## Test plan
- LW addr 0x100, ack in the first BUS cycle, bus_rdata 0xDEADBEEF: bus_addr=0x100, bus_be=4'hF; rdata_out=0xDEADBEEF with rdata_valid 2 cycles after req_valid; lsu_stall high exactly 2 cycles.
- SB addr 0x203, wdata 0x000000A5, ack delayed 3 cycles: bus_be=4'b1000, bus_wdata=0xA5A5A5A5 stable across the wait; rdata_valid after 5 cycles; rdata_out=0.
- LB/LBU addr 0x301, bus_rdata 0x00008000 then 0x0000F000, plus LH addr 0x302, bus_rdata 0x80000000: LB gives rdata_out 0xFFFFFF80, LBU gives 0x000000F0, LH gives 0xFFFF8000.
- No ack with TIMEOUT_CYCLES=4: bus_req drops after 4 BUS cycles; bus_err=1 and rdata_out=0 together with rdata_valid.
- LW addr 0x102: with LSU_MISALIGN_TRAP_EN, no bus_req and misalign_trap=1 one cycle after the request; without it, bus_addr=0x100 and misalign_trap=0.
- rst_n low during BUS with ack pending: next edge gives state IDLE, bus_req=0, no rdata_valid; a request after rst_n releases completes normally.
